// File: rtl/sprite_line_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : sprite_line_buffer_if                                      |
// | Brief   : Writer-side valid/ready pixel bus into the sprite line     |
// |           buffer (renderer is master, line buffer is slave).         |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
interface sprite_line_buffer_if #(
   parameter int PIX_W = 8
);
   logic             wr_valid;
   logic             wr_ready;
   logic [8:0]       wr_x;
   logic [PIX_W-1:0] wr_pix;

   modport master (output wr_valid, output wr_x, output wr_pix, input  wr_ready);
   modport slave  (input  wr_valid, input  wr_x, input  wr_pix, output wr_ready);
endinterface
`default_nettype wire

// File: rtl/sprite_line_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : sprite_line_buffer                                         |
// | Brief   : Double-buffered sprite line buffer. The renderer fills the |
// |           back bank while video reads (and clears) the front bank;   |
// |           banks swap at each hblank start.                           |
// |           Optional macro SPRITE_LINEBUF_PRIO_EN selects first-opaque |
// |           -wins read-modify-write; default is last-write-wins.       |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module sprite_line_buffer #(
   parameter int PIX_W  = 8,
   parameter int LINE_W = 512,
   parameter int H_OFS  = 0
) (
   input  wire                 clk,
   input  wire                 reset_n,
   input  wire                 clk_pix_en,
   input  wire  [8:0]          hc,
   input  wire  [8:0]          vc,
   input  wire                 hbl,
   sprite_line_buffer_if.slave wr,
   output logic                line_start,
   output logic [8:0]          line_vc,
   output logic [PIX_W-1:0]    rd_pix,
   output logic                busy
);
   localparam int            AW       = $clog2(LINE_W);
   localparam int            MW       = AW + 1;
   localparam logic [MW-1:0] CLR_LAST = MW'(2 * LINE_W - 1);
   localparam logic [8:0]    H_OFS_V  = 9'(H_OFS);

   typedef enum logic [0:0] {S_CLEAR, S_RUN} state_t;

   // Both banks in one array; the MSB of the address selects the bank.
   logic [PIX_W-1:0] mem [2*LINE_W];

   state_t           state_q, state_d;
   logic [MW-1:0]    clr_cnt_q, clr_cnt_d;
   logic             bank_q, bank_d;          // index of the front bank
   logic             hbl_dly_q, hbl_dly_d;    // hbl at the previous pixel
   logic             line_start_q, line_start_d;
   logic [8:0]       line_vc_q, line_vc_d;
   logic [PIX_W-1:0] rd_pix_q, rd_pix_d;
   logic             busy_q, busy_d;
   logic             rclr_pend_q, rclr_pend_d;
   logic [MW-1:0]    rclr_addr_q, rclr_addr_d;

   logic             run, swap_trig, swap_fire, wr_ready_w, wr_accept;
   logic             pa_we, pb_we;
   logic [MW-1:0]    pa_addr, rd_addr;
   logic [PIX_W-1:0] pa_data;
   logic [8:0]       rd_x;

`ifdef SPRITE_LINEBUF_PRIO_EN
   typedef enum logic [1:0] {W_IDLE, W_READ, W_WRITE} wstate_t;
   wstate_t          w_state_q, w_state_d;
   logic [AW-1:0]    rmw_x_q, rmw_x_d;
   logic [PIX_W-1:0] rmw_pix_q, rmw_pix_d;
   logic [PIX_W-1:0] rmw_old_q, rmw_old_d;
   logic             swap_pend_q, swap_pend_d;
`endif

   assign wr.wr_ready = wr_ready_w;
   assign line_start  = line_start_q;
   assign line_vc     = line_vc_q;
   assign rd_pix      = rd_pix_q;
   assign busy        = busy_q;

   // Next-state logic: clear sweep, swap, front-bank read/clear and writer port.
   always_comb begin
      state_d      = state_q;
      clr_cnt_d    = clr_cnt_q;
      bank_d       = bank_q;
      hbl_dly_d    = hbl_dly_q;
      line_start_d = 1'b0;
      line_vc_d    = line_vc_q;
      rd_pix_d     = rd_pix_q;
      busy_d       = busy_q;
      rclr_pend_d  = 1'b0;
      rclr_addr_d  = rclr_addr_q;
      pa_we        = 1'b0;
      pa_addr      = '0;
      pa_data      = '0;
      pb_we        = 1'b0;
      run          = (state_q == S_RUN);
      rd_x         = hc - H_OFS_V;
      rd_addr      = {bank_q, rd_x[AW-1:0]};
      swap_trig    = run & clk_pix_en & hbl & ~hbl_dly_q;
`ifdef SPRITE_LINEBUF_PRIO_EN
      w_state_d    = w_state_q;
      rmw_x_d      = rmw_x_q;
      rmw_pix_d    = rmw_pix_q;
      rmw_old_d    = rmw_old_q;
      // A swap never splits a read-modify-write; it waits for W_IDLE.
      swap_fire    = (swap_trig | swap_pend_q) & (w_state_q == W_IDLE);
      swap_pend_d  = run & (swap_trig | swap_pend_q) & ~swap_fire;
      wr_ready_w   = run & (w_state_q == W_IDLE) & ~swap_fire;
`else
      swap_fire    = swap_trig;
      wr_ready_w   = run & ~swap_fire;
`endif
      wr_accept    = wr.wr_valid & wr_ready_w;

      if (clk_pix_en) begin
         hbl_dly_d = hbl;
      end

      case (state_q)
         S_CLEAR: begin
            pa_we     = 1'b1;
            pa_addr   = clr_cnt_q;
            rd_pix_d  = '0;
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == CLR_LAST) begin
               state_d = S_RUN;
               busy_d  = 1'b0;
            end
         end
         default: begin
            // Clear-after-read lands the clk after the read on the same entry.
            pb_we = rclr_pend_q;
            if (clk_pix_en) begin
               if (hbl) begin
                  rd_pix_d = '0;
               end else begin
                  rd_pix_d    = mem[rd_addr];
                  rclr_pend_d = 1'b1;
                  rclr_addr_d = rd_addr;
               end
            end
            if (swap_fire) begin
               bank_d       = ~bank_q;
               line_start_d = 1'b1;
               line_vc_d    = vc + 9'd1;
            end
`ifdef SPRITE_LINEBUF_PRIO_EN
            case (w_state_q)
               W_IDLE: begin
                  if (wr_accept) begin
                     w_state_d = W_READ;
                     rmw_x_d   = wr.wr_x[AW-1:0];
                     rmw_pix_d = wr.wr_pix;
                  end
               end
               W_READ: begin
                  rmw_old_d = mem[{~bank_q, rmw_x_q}];
                  w_state_d = W_WRITE;
               end
               default: begin
                  // First opaque pixel at a position is kept.
                  if ((rmw_old_q[3:0] == 4'd0) && (rmw_pix_q[3:0] != 4'd0)) begin
                     pa_we   = 1'b1;
                     pa_addr = {~bank_q, rmw_x_q};
                     pa_data = rmw_pix_q;
                  end
                  w_state_d = W_IDLE;
               end
            endcase
`else
            // Transparent pixels are accepted but never stored.
            if (wr_accept && (wr.wr_pix[3:0] != 4'd0)) begin
               pa_we   = 1'b1;
               pa_addr = {~bank_q, wr.wr_x[AW-1:0]};
               pa_data = wr.wr_pix;
            end
`endif
         end
      endcase
   end

   // State registers; reset restarts the full clear sweep.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= S_CLEAR;
         clr_cnt_q    <= '0;
         bank_q       <= 1'b0;
         hbl_dly_q    <= 1'b0;
         line_start_q <= 1'b0;
         line_vc_q    <= '0;
         rd_pix_q     <= '0;
         busy_q       <= 1'b1;
         rclr_pend_q  <= 1'b0;
         rclr_addr_q  <= '0;
`ifdef SPRITE_LINEBUF_PRIO_EN
         w_state_q    <= W_IDLE;
         rmw_x_q      <= '0;
         rmw_pix_q    <= '0;
         rmw_old_q    <= '0;
         swap_pend_q  <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         clr_cnt_q    <= clr_cnt_d;
         bank_q       <= bank_d;
         hbl_dly_q    <= hbl_dly_d;
         line_start_q <= line_start_d;
         line_vc_q    <= line_vc_d;
         rd_pix_q     <= rd_pix_d;
         busy_q       <= busy_d;
         rclr_pend_q  <= rclr_pend_d;
         rclr_addr_q  <= rclr_addr_d;
`ifdef SPRITE_LINEBUF_PRIO_EN
         w_state_q    <= w_state_d;
         rmw_x_q      <= rmw_x_d;
         rmw_pix_q    <= rmw_pix_d;
         rmw_old_q    <= rmw_old_d;
         swap_pend_q  <= swap_pend_d;
`endif
      end
   end

   // Storage: port A (writer / clear sweep) and port B (clear-after-read).
   // They always address opposite banks; writes in reset are dropped.
   always_ff @(posedge clk) begin
      if (reset_n) begin
         if (pa_we) begin
            mem[pa_addr] <= pa_data;
         end
         if (pb_we) begin
            mem[rclr_addr_q] <= '0;
         end
      end
   end
endmodule
`default_nettype wire
